// File: rtl/obuf_pixel_reader_pkg.sv
// Shared definitions for the output-buffer pixel reader: RGB565 layout, expansion, defaults.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package obuf_pixel_reader_pkg;

  // Default frame geometry (VGA)
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  // RGB565 word layout
  localparam int RGB565_W = 16;
  localparam int R_HI     = 15;
  localparam int R_LO     = 11;
  localparam int G_HI     = 10;
  localparam int G_LO     = 5;
  localparam int B_HI     = 4;
  localparam int B_LO     = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  // Widen each channel by replicating its MSBs into the new LSBs so that
  // full-scale maps to 8'hFF and zero stays zero.
  function automatic rgb888_t rgb565_expand(input logic [RGB565_W-1:0] p);
    rgb888_t c;
    c.r = {p[R_HI:R_LO], p[R_HI -: 3]};
    c.g = {p[G_HI:G_LO], p[G_HI -: 2]};
    c.b = {p[B_HI:B_LO], p[B_HI -: 3]};
    return c;
  endfunction

endpackage

// File: rtl/obuf_pixel_reader_skid.sv
// Two-entry valid/ready buffer holding tagged pixels between FIFO capture and the output stream.
// Latency: 1 cycle from write to rd_vld; head register drives rd_dat directly.
// Backpressure: holds head stable while rd_vld & ~rd_rdy; writer must keep occ+inflight within 2.
module pix_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic [1:0]   occ
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   occ_q;
  logic         push;
  logic         pop;

  assign rd_vld = (occ_q != 2'd0);
  assign rd_dat = head_q;
  assign occ    = occ_q;
  assign pop    = rd_vld & rd_rdy;
  // A write into a full buffer is only accepted if a slot frees up this cycle
  assign push   = wr_vld & ((occ_q != 2'd2) | pop);

  // Head/tail storage and occupancy; flush empties without touching the data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      occ_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= wr_dat;
          else               tail_q <= wr_dat;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_q <= tail_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= wr_dat;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/obuf_pixel_reader.sv
// Pops RGB565 words from the camera output FIFO, tags x/y and frame markers, expands to RGB888.
// Latency: 2 cycles from read-enable to o_valid (1 FIFO read latency + 1 capture register).
// Backpressure: i_ready low stalls the head pixel; reads throttle so buffered + in-flight <= 2.
module obuf_pixel_reader
  import obuf_pixel_reader_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_enable,
  input  logic                i_resync,
  input  logic                i_obuf_empty,
  input  logic [RGB565_W-1:0] i_obuf_data,
  output logic                o_obuf_rd,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [RGB565_W-1:0] o_pix,
  output logic [7:0]          o_r,
  output logic [7:0]          o_g,
  output logic [7:0]          o_b,
  output logic [X_W-1:0]      o_x,
  output logic [Y_W-1:0]      o_y,
  output logic                o_sof,
  output logic                o_eol,
  output logic                o_eof,
  output logic                o_frame_done
);

  localparam int             PW     = RGB565_W + X_W + Y_W + 3;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  rd_state_t      state_q;
  logic           rd_armed_q;
  logic           inflight_q;
  logic [X_W-1:0] wr_x_q;
  logic [Y_W-1:0] wr_y_q;
  logic [1:0]     occ;
  logic [2:0]     pend;
  logic           buf_vld;
  logic           pop;
  logic           room;
  logic           cap_vld;
  logic           wr_sof;
  logic           wr_eol;
  logic           wr_eof;
  logic [PW-1:0]  wr_dat;
  logic [PW-1:0]  rd_dat;
  rgb888_t        rgb;

  // Words owed to the buffer: stored entries plus the read whose data lands next cycle.
  // The pop this cycle frees a slot in time for a new read, which keeps 1 pixel/cycle.
  assign pop  = buf_vld & i_ready;
  assign pend = {1'b0, occ} + {2'b00, inflight_q};
  assign room = (pend < 3'd2) | ((pend == 3'd2) & pop);

  assign o_obuf_rd = rd_armed_q & i_enable & ~i_obuf_empty & ~i_resync & room;

  // Data returning during a resync belongs to the abandoned stream and is dropped
  assign cap_vld = inflight_q & ~i_resync;

  assign wr_sof = (wr_x_q == '0) & (wr_y_q == '0);
  assign wr_eol = (wr_x_q == X_LAST);
  assign wr_eof = wr_eol & (wr_y_q == Y_LAST);
  assign wr_dat = {i_obuf_data, wr_x_q, wr_y_q, wr_sof, wr_eol, wr_eof};

  pix_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk    (i_clk),
    .rst_n  (i_rstn),
    .flush  (i_resync),
    .wr_vld (cap_vld),
    .wr_dat (wr_dat),
    .rd_vld (buf_vld),
    .rd_rdy (i_ready),
    .rd_dat (rd_dat),
    .occ    (occ)
  );

  assign o_valid = buf_vld;
  assign {o_pix, o_x, o_y, o_sof, o_eol, o_eof} = rd_dat;

  assign rgb = rgb565_expand(o_pix);
  assign o_r = rgb.r;
  assign o_g = rgb.g;
  assign o_b = rgb.b;

  // Read pipeline: hold off reads for the first cycle out of reset, track the in-flight word
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_armed_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      rd_armed_q <= 1'b1;
      inflight_q <= o_obuf_rd;
    end
  end

  // Write-side raster position, advanced once per captured word
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_x_q <= '0;
      wr_y_q <= '0;
    end else if (i_resync) begin
      wr_x_q <= '0;
      wr_y_q <= '0;
    end else if (cap_vld) begin
      if (wr_eol) begin
        wr_x_q <= '0;
        wr_y_q <= (wr_y_q == Y_LAST) ? '0 : wr_y_q + Y_W'(1);
      end else begin
        wr_x_q <= wr_x_q + X_W'(1);
      end
    end
  end

  // Fetch state tracking and the end-of-frame pulse
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= pop & o_eof;
      if (i_resync) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE:  if (i_enable) state_q <= ST_RUN;
          ST_RUN:   if (!i_enable) state_q <= ST_DRAIN;
          ST_DRAIN: begin
            if (i_enable)           state_q <= ST_RUN;
            else if (pend == 3'd0)  state_q <= ST_IDLE;
          end
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obuf_pixel_reader.sv
// Directed bench for obuf_pixel_reader with a 4x3 frame, FIFO model and accept scoreboard.
module tb_obuf_pixel_reader;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_enable;
  logic        i_resync;
  logic        i_obuf_empty;
  logic [15:0] i_obuf_data;
  logic        o_obuf_rd;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_pix;
  logic [7:0]  o_r, o_g, o_b;
  logic [1:0]  o_x;
  logic [1:0]  o_y;
  logic        o_sof, o_eol, o_eof, o_frame_done;

  obuf_pixel_reader #(.IMG_W(4), .IMG_H(3), .X_W(2), .Y_W(2)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_resync(i_resync),
    .i_obuf_empty(i_obuf_empty), .i_obuf_data(i_obuf_data), .o_obuf_rd(o_obuf_rd),
    .o_valid(o_valid), .i_ready(i_ready), .o_pix(o_pix), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] pix;
    logic [7:0]  r, g, b;
    logic [1:0]  x, y;
    logic        sof, eol, eof;
  } rec_t;

  typedef struct {
    logic [15:0] pix;
    logic [7:0]  r, g, b;
    int          x, y;
    logic        sof, eol, eof;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // FIFO model: data appears the cycle after a read
  logic [15:0] fifo_mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        rd_q = 1'b0;
  assign i_obuf_empty = (wr_ptr == rd_ptr);

  always @(posedge i_clk) begin
    if (rd_q) begin
      i_obuf_data <= fifo_mem[rd_ptr];
      rd_ptr      <= rd_ptr + 8'd1;
    end else begin
      i_obuf_data <= 16'hDEAD;
    end
  end

  // Monitor (mid-cycle): accepted pixels, frame_done timing, stall stability, read limits
  rec_t        acc_mem [0:63];
  int          acc_cnt = 0;
  int          pend = 0;
  int          pop_i;
  int          rdempty_err = 0, ovf_err = 0, stall_err = 0, fd_err = 0, fd_cnt = 0, held_cnt = 0;
  logic        fd_exp = 1'b0;
  logic        stall_prev = 1'b0;
  logic        resync_prev = 1'b0;
  logic [22:0] pay_prev = '0;

  always @(negedge i_clk) begin
    if (i_rstn) begin
      rd_q  = o_obuf_rd;
      pop_i = (o_valid && i_ready) ? 1 : 0;
      if (o_obuf_rd && i_obuf_empty) rdempty_err++;
      if (i_enable && !i_obuf_empty && !i_resync && !o_obuf_rd) held_cnt++;
      if (i_resync) pend = 0;
      else begin
        if (o_obuf_rd && (pend - pop_i >= 2)) ovf_err++;
        pend = pend + (o_obuf_rd ? 1 : 0) - pop_i;
      end
      if (o_valid && i_ready) begin
        acc_mem[acc_cnt] = {o_pix, o_r, o_g, o_b, o_x, o_y, o_sof, o_eol, o_eof};
        acc_cnt++;
      end
      if (o_frame_done !== fd_exp) fd_err++;
      if (o_frame_done) fd_cnt++;
      fd_exp = o_valid && i_ready && o_eof;
      if (stall_prev && !resync_prev &&
          (!o_valid || {o_pix, o_x, o_y, o_sof, o_eol, o_eof} !== pay_prev)) stall_err++;
      stall_prev  = o_valid && !i_ready;
      resync_prev = i_resync;
      pay_prev    = {o_pix, o_x, o_y, o_sof, o_eol, o_eof};
    end else begin
      rd_q = 1'b0;
    end
  end

  int chk_idx = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  function automatic rec_t mk(input logic [15:0] pix, input logic [7:0] r, g, b,
                              input int x, y, input logic sof, eol, eof);
    return {pix, r, g, b, 2'(x), 2'(y), sof, eol, eof};
  endfunction

  task automatic check_acc(input rec_t exp, input bit use_rgb, input string nm);
    rec_t got;
    bit   ok;
    for (int t = 0; t < 200 && acc_cnt <= chk_idx; t++) step();
    checks++;
    if (acc_cnt <= chk_idx) begin
      errors++;
      $display("FAIL %s: no pixel accepted within cycle budget, want pix=%h", nm, exp.pix);
    end else begin
      got = acc_mem[chk_idx];
      chk_idx++;
      ok = (got.pix == exp.pix) && (got.x == exp.x) && (got.y == exp.y) &&
           (got.sof == exp.sof) && (got.eol == exp.eol) && (got.eof == exp.eof) &&
           (!use_rgb || ((got.r == exp.r) && (got.g == exp.g) && (got.b == exp.b)));
      if (!ok) begin
        errors++;
        $display("FAIL %s: got pix=%h rgb=%h/%h/%h xy=(%0d,%0d) sof=%b eol=%b eof=%b, want pix=%h rgb=%h/%h/%h xy=(%0d,%0d) sof=%b eol=%b eof=%b",
                 nm, got.pix, got.r, got.g, got.b, got.x, got.y, got.sof, got.eol, got.eof,
                 exp.pix, exp.r, exp.g, exp.b, exp.x, exp.y, exp.sof, exp.eol, exp.eof);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  initial begin
    vec_t vec [0:12];
    int   held0;

    // Full 4x3 frame plus the first pixel of the next frame
    vec[0]  = '{16'hF800, 8'hFF, 8'h00, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{16'h07E0, 8'h00, 8'hFF, 8'h00, 1, 0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{16'h001F, 8'h00, 8'h00, 8'hFF, 2, 0, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{16'h0000, 8'h00, 8'h00, 8'h00, 3, 0, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{16'h8410, 8'h84, 8'h82, 8'h84, 1, 1, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{16'h1234, 8'h10, 8'h45, 8'hA5, 2, 1, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{16'h001F, 8'h00, 8'h00, 8'hFF, 3, 1, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{16'h07E0, 8'h00, 8'hFF, 8'h00, 0, 2, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{16'hF800, 8'hFF, 8'h00, 8'h00, 1, 2, 1'b0, 1'b0, 1'b0};
    vec[10] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 2, 2, 1'b0, 1'b0, 1'b0};
    vec[11] = '{16'h8410, 8'h84, 8'h82, 8'h84, 3, 2, 1'b0, 1'b1, 1'b1};
    vec[12] = '{16'h1234, 8'h10, 8'h45, 8'hA5, 0, 0, 1'b1, 1'b0, 1'b0};

    i_rstn = 1'b0; i_enable = 1'b0; i_resync = 1'b0; i_ready = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_rd", o_obuf_rd, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_pix", o_pix, 0);
    chk("rst_rgb", {o_r, o_g, o_b}, 0);
    chk("rst_xy", {o_x, o_y}, 0);
    chk("rst_flags", {o_sof, o_eol, o_eof}, 0);
    chk("rst_frame_done", o_frame_done, 0);

    i_rstn = 1'b1;
    step(); step();

    // Four words waiting, enable rises: first pixel two cycles later, then back-to-back
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    #1;
    chk("A_no_rd_disabled", o_obuf_rd, 0);
    i_enable = 1'b1;
    #1;
    chk("A_rd_on_enable", o_obuf_rd, 1);
    step(); chk("A_valid_e1", o_valid, 0);
    step(); chk("A_valid_e2", o_valid, 1); chk("A_sof_first", o_sof, 1);
    step(); chk("A_valid_e3", o_valid, 1); chk("A_sof_second", o_sof, 0);
    step(); chk("A_valid_e4", o_valid, 1);
    step(); chk("A_valid_e5", o_valid, 1);
    step(); chk("A_valid_e6", o_valid, 0);
    check_acc(mk(16'h1111, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0), 1'b0, "A_pix0");
    check_acc(mk(16'h2222, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0), 1'b0, "A_pix1");
    check_acc(mk(16'h3333, 0, 0, 0, 2, 0, 1'b0, 1'b0, 1'b0), 1'b0, "A_pix2");
    check_acc(mk(16'h4444, 0, 0, 0, 3, 0, 1'b0, 1'b1, 1'b0), 1'b0, "A_pix3");

    // Restart the raster, then stream a whole frame from the vector table
    i_resync = 1'b1;
    step();
    i_resync = 1'b0;
    for (int i = 0; i < 13; i++) push(vec[i].pix);
    for (int i = 0; i < 13; i++)
      check_acc(mk(vec[i].pix, vec[i].r, vec[i].g, vec[i].b, vec[i].x, vec[i].y,
                   vec[i].sof, vec[i].eol, vec[i].eof), 1'b1, $sformatf("T_vec%0d", i));
    step(); step();
    chk("T_frame_done_count", fd_cnt, 1);

    // Ready toggling with data always available: reads throttle, nothing lost or repeated
    held0 = held_cnt;
    for (int k = 0; k < 8; k++) push(16'hA000 + 16'(k));
    for (int c = 0; c < 16; c++) begin
      i_ready = (c % 2 == 0);
      step();
    end
    i_ready = 1'b1;
    check_acc(mk(16'hA000, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0), 1'b0, "B_pix0");
    check_acc(mk(16'hA001, 0, 0, 0, 2, 0, 1'b0, 1'b0, 1'b0), 1'b0, "B_pix1");
    check_acc(mk(16'hA002, 0, 0, 0, 3, 0, 1'b0, 1'b1, 1'b0), 1'b0, "B_pix2");
    check_acc(mk(16'hA003, 0, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0), 1'b0, "B_pix3");
    check_acc(mk(16'hA004, 0, 0, 0, 1, 1, 1'b0, 1'b0, 1'b0), 1'b0, "B_pix4");
    check_acc(mk(16'hA005, 0, 0, 0, 2, 1, 1'b0, 1'b0, 1'b0), 1'b0, "B_pix5");
    check_acc(mk(16'hA006, 0, 0, 0, 3, 1, 1'b0, 1'b1, 1'b0), 1'b0, "B_pix6");
    check_acc(mk(16'hA007, 0, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0), 1'b0, "B_pix7");
    chk("B_rd_throttled", held_cnt > held0, 1);

    // FIFO runs dry mid-line, then refills
    step();
    push(16'hC001); push(16'hC002);
    #1;
    chk("C_rd0", o_obuf_rd, 1);
    step(); chk("C_rd1", o_obuf_rd, 1);
    step(); chk("C_rd_empty", o_obuf_rd, 0);
    step(); step(); step();
    chk("C_gap_valid", o_valid, 0);
    push(16'hC003); push(16'hC004);
    check_acc(mk(16'hC001, 0, 0, 0, 1, 2, 1'b0, 1'b0, 1'b0), 1'b0, "C_pix0");
    check_acc(mk(16'hC002, 0, 0, 0, 2, 2, 1'b0, 1'b0, 1'b0), 1'b0, "C_pix1");
    check_acc(mk(16'hC003, 0, 0, 0, 3, 2, 1'b0, 1'b1, 1'b1), 1'b0, "C_pix2");
    check_acc(mk(16'hC004, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0), 1'b0, "C_pix3");
    step(); step();
    chk("C_frame_done_count", fd_cnt, 2);

    // Resync right after a read: buffered pixel and in-flight word are dropped
    i_ready = 1'b0;
    push(16'hD000); push(16'hD001); push(16'hD002); push(16'hD003);
    #1;
    chk("D_rd0", o_obuf_rd, 1);
    step(); chk("D_rd1", o_obuf_rd, 1);
    step(); chk("D_rd_blocked", o_obuf_rd, 0);
    step();
    i_ready = 1'b1;
    #1;
    chk("D_rd_with_pop", o_obuf_rd, 1);
    step();
    i_ready = 1'b0; i_resync = 1'b1;
    #1;
    chk("D_rd_resync", o_obuf_rd, 0);
    step();
    i_resync = 1'b0; i_ready = 1'b1;
    chk("D_valid_flushed", o_valid, 0);
    check_acc(mk(16'hD000, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0), 1'b0, "D_pix_before");
    check_acc(mk(16'hD003, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0), 1'b0, "D_pix_after");

    repeat (6) step();
    chk("no_extra_pixels", acc_cnt, chk_idx);
    chk("no_read_on_empty", rdempty_err, 0);
    chk("no_overcommit", ovf_err, 0);
    chk("stall_stable", stall_err, 0);
    chk("frame_done_timing", fd_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
